// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Holds the 4-bit operation codes (also consumed by ALU control), the
// iterative ALU state encoding and the op classification helpers.
package alu_pkg;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned CntWidth  = 6;  // holds 0..32

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b0001;
  localparam logic [3:0] OpAnd  = 4'b0010;
  localparam logic [3:0] OpOr   = 4'b0011;
  localparam logic [3:0] OpLui  = 4'b0100;
  localparam logic [3:0] OpXor  = 4'b0101;
  localparam logic [3:0] OpSll  = 4'b0110;
  localparam logic [3:0] OpSrl  = 4'b0111;
  localparam logic [3:0] OpSra  = 4'b1000;
  localparam logic [3:0] OpSlt  = 4'b1001;
  localparam logic [3:0] OpSltu = 4'b1010;
  localparam logic [3:0] OpMul  = 4'b1011;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } alu_state_e;

  function automatic logic is_shift(input logic [3:0] op);
    return (op == OpSll) || (op == OpSrl) || (op == OpSra);
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return op == OpMul;
  endfunction

endpackage

// File: rtl/iterative_alu_if.sv
// Request/response bundle between the execute stage and the iterative ALU.
//   start_i, ALU_Operation_i, A_i, B_i : request side (driven by the master)
//   result_o, zero_o, busy_o, done_o   : response side (driven by the ALU)
interface iterative_alu_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  start_i;
  logic [3:0]            ALU_Operation_i;
  logic [DATA_WIDTH-1:0] A_i;
  logic [DATA_WIDTH-1:0] B_i;
  logic [DATA_WIDTH-1:0] result_o;
  logic                  zero_o;
  logic                  busy_o;
  logic                  done_o;

  modport master (
    output start_i,
    output ALU_Operation_i,
    output A_i,
    output B_i,
    input  result_o,
    input  zero_o,
    input  busy_o,
    input  done_o
  );

  modport slave (
    input  start_i,
    input  ALU_Operation_i,
    input  A_i,
    input  B_i,
    output result_o,
    output zero_o,
    output busy_o,
    output done_o
  );

endinterface

// File: rtl/alu_simple_comb.sv
// Single-cycle combinational ALU for the non-iterative ops:
// ADD/SUB/AND/OR/XOR/LUI/SLT/SLTU. Shift, MUL and illegal codes return 0
// (the iterative ops are never selected from this unit).
//   op_i     : 4-bit operation code
//   a_i, b_i : operands
//   result_o : combinational result
module alu_simple_comb
  import alu_pkg::*;
(
  input  logic [3:0]           op_i,
  input  logic [DataWidth-1:0] a_i,
  input  logic [DataWidth-1:0] b_i,
  output logic [DataWidth-1:0] result_o
);

  always_comb begin
    result_o = '0;
    case (op_i)
      OpAdd:   result_o = a_i + b_i;
      OpSub:   result_o = a_i - b_i;
      OpAnd:   result_o = a_i & b_i;
      OpOr:    result_o = a_i | b_i;
      OpLui:   result_o = b_i;
      OpXor:   result_o = a_i ^ b_i;
      OpSlt:   result_o = {{(DataWidth-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      OpSltu:  result_o = {{(DataWidth-1){1'b0}}, (a_i < b_i)};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/iterative_alu.sv
// Variable-latency execute-stage ALU.
// Simple ops finish in one cycle, shifts move one bit per cycle and MUL is a
// shift-add loop that stops as soon as the remaining multiplier is zero.
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset
//   bus   : slave side of iterative_alu_if (start/op/A/B in,
//           result/zero/busy/done out)
module iterative_alu
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  iterative_alu_if.slave bus
);

  alu_state_e            state_q, state_d;
  logic [3:0]            op_q, op_d;
  // Shift working register, or the multiplicand during MUL.
  logic [DataWidth-1:0]  work_q, work_d;
  logic [DataWidth-1:0]  mplier_q, mplier_d;
  logic [DataWidth-1:0]  acc_q, acc_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [DataWidth-1:0]  result_q, result_d;
  logic                  zero_q, zero_d;

  logic [DataWidth-1:0]  simple_res;
  logic [DataWidth-1:0]  acc_next;
  logic [DataWidth-1:0]  mplier_next;
  logic [DataWidth-1:0]  shift_next;

  alu_simple_comb u_simple (
    .op_i     (bus.ALU_Operation_i),
    .a_i      (bus.A_i),
    .b_i      (bus.B_i),
    .result_o (simple_res)
  );

  // One-bit step of the shift engine.
  always_comb begin
    shift_next = work_q;
    case (op_q)
      OpSll:   shift_next = {work_q[DataWidth-2:0], 1'b0};
      OpSrl:   shift_next = {1'b0, work_q[DataWidth-1:1]};
      OpSra:   shift_next = {work_q[DataWidth-1], work_q[DataWidth-1:1]};
      default: shift_next = work_q;
    endcase
  end

  // One step of the shift-add multiplier.
  always_comb begin
    acc_next    = mplier_q[0] ? (acc_q + work_q) : acc_q;
    mplier_next = {1'b0, mplier_q[DataWidth-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;

    case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          if (is_shift(bus.ALU_Operation_i)) begin
            if (bus.B_i[4:0] == 5'd0) begin
              result_d = bus.A_i;
              zero_d   = (bus.A_i == '0);
              state_d  = StDone;
            end else begin
              op_d    = bus.ALU_Operation_i;
              work_d  = bus.A_i;
              cnt_d   = {1'b0, bus.B_i[4:0]};
              state_d = StRun;
            end
          end else if (is_mul(bus.ALU_Operation_i)) begin
            if (bus.B_i == '0) begin
              // Nothing to accumulate: product is zero.
              result_d = '0;
              zero_d   = 1'b1;
              state_d  = StDone;
            end else begin
              op_d     = bus.ALU_Operation_i;
              work_d   = bus.A_i;
              mplier_d = bus.B_i;
              acc_d    = '0;
              cnt_d    = CntWidth'(DataWidth);
              state_d  = StRun;
            end
          end else begin
            result_d = simple_res;
            zero_d   = (simple_res == '0);
            state_d  = StDone;
          end
        end
      end

      StRun: begin
        cnt_d = cnt_q - CntWidth'(1);
        if (is_mul(op_q)) begin
          acc_d    = acc_next;
          work_d   = {work_q[DataWidth-2:0], 1'b0};
          mplier_d = mplier_next;
          // Early exit once no multiplier bits remain.
          if ((mplier_next == '0) || (cnt_q == CntWidth'(1))) begin
            result_d = acc_next;
            zero_d   = (acc_next == '0);
            state_d  = StDone;
          end
        end else begin
          work_d = shift_next;
          if (cnt_q == CntWidth'(1)) begin
            result_d = shift_next;
            zero_d   = (shift_next == '0);
            state_d  = StDone;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      work_q   <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.result_o = result_q;
  assign bus.zero_o   = zero_q;
  assign bus.busy_o   = (state_q == StRun);
  assign bus.done_o   = (state_q == StDone);

endmodule
